// File: rtl/projectile_arbiter.sv
// Round-robin arbiter that shares one projectile between player and NPC, tracks
// the flight until hit / out-of-bounds / timeout, then holds a frame-based cooldown.
module projectile_arbiter #(
  parameter int unsigned COOLDOWN_FRAMES   = 8,
  parameter int unsigned MAX_FLIGHT_FRAMES = 160,
  parameter logic [9:0]  X_MIN             = 10'd0,
  parameter logic [9:0]  X_MAX             = 10'd639
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       battle_l,
  input  logic       P_Shoot,
  input  logic       N_Shoot,
  input  logic [9:0] P_X_Center,
  input  logic [9:0] P_Y_Center,
  input  logic [9:0] N_X_Center,
  input  logic [9:0] N_Y_Center,
  input  logic [9:0] Proj_X_Curr,
  input  logic       contact_player,
  input  logic       contact_npc,
  output logic [9:0] Proj_Origin_X,
  output logic [9:0] Proj_Origin_Y,
  output logic       Proj_Dir,
  output logic       proj_activate,
  output logic       proj_kill,
  output logic       proj_owner,
  output logic       proj_busy,
  output logic       hit_player,
  output logic       hit_npc
);
  typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, COOLDOWN} state_t;

  localparam logic [7:0] CD_LIM = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] FL_LIM = 8'(MAX_FLIGHT_FRAMES);

  state_t      state_q;
  logic        frame_q, p_shoot_q, n_shoot_q;
  logic        p_pend_q, n_pend_q, pref_npc_q;
  logic [7:0]  fcnt_q, ccnt_q, fcnt_d, ccnt_d;
  logic [9:0]  org_x_q, org_y_q;
  logic        dir_q, owner_q, act_q, kill_q, busy_q, hit_p_q, hit_n_q;
  logic        ftick, p_rise, n_rise, p_req, n_req, grant_npc, tgt_hit, oob;
  logic [10:0] dlo, dhi;

  always_comb begin
    ftick     = frame_clk & ~frame_q;
    p_rise    = P_Shoot & ~p_shoot_q;
    n_rise    = N_Shoot & ~n_shoot_q;
    p_req     = p_pend_q | p_rise;
    n_req     = n_pend_q | n_rise;
    grant_npc = n_req & (~p_req | pref_npc_q);
    fcnt_d    = fcnt_q;
    if (ftick && fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    ccnt_d    = ccnt_q;
    if (ftick && ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
    tgt_hit   = owner_q ? contact_player : contact_npc;
    // Bounds via 11-bit differences: the sign bit flags below-min / above-max.
    dlo       = {1'b0, Proj_X_Curr} - {1'b0, X_MIN};
    dhi       = {1'b0, X_MAX} - {1'b0, Proj_X_Curr};
    oob       = dlo[10] | dhi[10];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      frame_q    <= 1'b0;
      p_shoot_q  <= 1'b0;
      n_shoot_q  <= 1'b0;
      p_pend_q   <= 1'b0;
      n_pend_q   <= 1'b0;
      pref_npc_q <= 1'b0;
      fcnt_q     <= '0;
      ccnt_q     <= '0;
      org_x_q    <= '0;
      org_y_q    <= '0;
      dir_q      <= 1'b0;
      owner_q    <= 1'b0;
      act_q      <= 1'b0;
      kill_q     <= 1'b0;
      busy_q     <= 1'b0;
      hit_p_q    <= 1'b0;
      hit_n_q    <= 1'b0;
    end else begin
      frame_q   <= frame_clk;
      p_shoot_q <= P_Shoot;
      n_shoot_q <= N_Shoot;
      act_q     <= 1'b0;
      kill_q    <= 1'b0;
      hit_p_q   <= 1'b0;
      hit_n_q   <= 1'b0;
      if (!battle_l) begin
        // Leaving battle aborts any live shot; the fairness pointer survives.
        state_q  <= IDLE;
        p_pend_q <= 1'b0;
        n_pend_q <= 1'b0;
        busy_q   <= 1'b0;
        if (state_q == LAUNCH || state_q == FLIGHT) kill_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (p_req || n_req) begin
            state_q    <= LAUNCH;
            act_q      <= 1'b1;
            busy_q     <= 1'b1;
            owner_q    <= grant_npc;
            pref_npc_q <= ~grant_npc;
            org_x_q    <= grant_npc ? N_X_Center : P_X_Center;
            org_y_q    <= grant_npc ? N_Y_Center : P_Y_Center;
            dir_q      <= grant_npc ? (P_X_Center < N_X_Center) : (N_X_Center < P_X_Center);
            p_pend_q   <= grant_npc & p_req;
            n_pend_q   <= ~grant_npc & n_req;
          end
          LAUNCH: begin
            state_q <= FLIGHT;
            fcnt_q  <= '0;
          end
          FLIGHT: begin
            fcnt_q <= fcnt_d;
            if (tgt_hit || oob || fcnt_d == FL_LIM) begin
              state_q <= COOLDOWN;
              ccnt_q  <= '0;
              kill_q  <= 1'b1;
              busy_q  <= 1'b0;
              hit_p_q <= tgt_hit & owner_q;
              hit_n_q <= tgt_hit & ~owner_q;
            end
          end
          COOLDOWN: begin
            ccnt_q   <= ccnt_d;
            p_pend_q <= p_pend_q | p_rise;
            n_pend_q <= n_pend_q | n_rise;
            if (ccnt_d == CD_LIM) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Proj_Origin_X = org_x_q;
  assign Proj_Origin_Y = org_y_q;
  assign Proj_Dir      = dir_q;
  assign proj_activate = act_q;
  assign proj_kill     = kill_q;
  assign proj_owner    = owner_q;
  assign proj_busy     = busy_q;
  assign hit_player    = hit_p_q;
  assign hit_npc       = hit_n_q;
endmodule

// File: tb/tb_projectile_arbiter.sv
// Bench for projectile_arbiter: vector table, scripted corner sequences and a
// randomized run, all checked against an event-level model of the arbiter.
module tb_projectile_arbiter;
  localparam int CDF = 8, MAXF = 160, XMIN = 0, XMAX = 639;

  logic       Clk, Reset, frame_clk, battle_l, P_Shoot, N_Shoot;
  logic       contact_player, contact_npc;
  logic [9:0] P_X_Center, P_Y_Center, N_X_Center, N_Y_Center, Proj_X_Curr;
  logic [9:0] Proj_Origin_X, Proj_Origin_Y;
  logic       Proj_Dir, proj_activate, proj_kill, proj_owner, proj_busy;
  logic       hit_player, hit_npc;

  projectile_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .battle_l(battle_l),
    .P_Shoot(P_Shoot), .N_Shoot(N_Shoot),
    .P_X_Center(P_X_Center), .P_Y_Center(P_Y_Center),
    .N_X_Center(N_X_Center), .N_Y_Center(N_Y_Center),
    .Proj_X_Curr(Proj_X_Curr), .contact_player(contact_player), .contact_npc(contact_npc),
    .Proj_Origin_X(Proj_Origin_X), .Proj_Origin_Y(Proj_Origin_Y), .Proj_Dir(Proj_Dir),
    .proj_activate(proj_activate), .proj_kill(proj_kill), .proj_owner(proj_owner),
    .proj_busy(proj_busy), .hit_player(hit_player), .hit_npc(hit_npc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  int n_act, n_kill, n_hp, n_hn;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference model: tracks "shot in the air", frames left to rest, and
  // per-shooter pending requests; outputs are what should appear after the edge.
  bit m_launching, m_flying, m_pp, m_np, m_pf, m_pps, m_pns;
  int m_cool, m_fticks, m_last;
  bit e_act, e_kill, e_busy, e_hp, e_hn, e_own, e_dir;
  logic [9:0] e_ox, e_oy;

  task automatic model_step();
    bit tick, pr, nr, rp, rn, hit, outb;
    int w, x;
    if (Reset) begin
      {m_launching, m_flying, m_pp, m_np, m_pf, m_pps, m_pns} = '0;
      m_cool = 0; m_fticks = 0; m_last = 1;
      {e_act, e_kill, e_busy, e_hp, e_hn, e_own, e_dir} = '0;
      e_ox = '0; e_oy = '0;
      return;
    end
    tick = frame_clk && !m_pf;
    pr = P_Shoot && !m_pps;
    nr = N_Shoot && !m_pns;
    m_pf = frame_clk; m_pps = P_Shoot; m_pns = N_Shoot;
    {e_act, e_kill, e_hp, e_hn} = '0;
    if (!battle_l) begin
      if (m_launching || m_flying) e_kill = 1;
      m_launching = 0; m_flying = 0; m_cool = 0; m_pp = 0; m_np = 0; e_busy = 0;
    end else if (m_launching) begin
      m_launching = 0; m_flying = 1; m_fticks = 0;
    end else if (m_flying) begin
      if (tick && m_fticks < 255) m_fticks++;
      hit = e_own ? contact_player : contact_npc;
      x = int'(Proj_X_Curr);
      outb = (x < XMIN) || (x > XMAX);
      if (hit) begin
        if (e_own) e_hp = 1; else e_hn = 1;
      end
      if (hit || outb || m_fticks == MAXF) begin
        e_kill = 1; m_flying = 0; m_cool = CDF; e_busy = 0;
      end
    end else if (m_cool > 0) begin
      m_pp = m_pp | pr; m_np = m_np | nr;
      if (tick) m_cool--;
    end else begin
      rp = m_pp | pr; rn = m_np | nr;
      if (rp || rn) begin
        w = (rp && rn) ? 1 - m_last : (rn ? 1 : 0);
        m_last = w;
        e_act = 1; e_busy = 1; m_launching = 1; e_own = (w == 1);
        if (w == 1) begin
          e_ox = N_X_Center; e_oy = N_Y_Center; e_dir = (P_X_Center < N_X_Center);
          m_np = 0; m_pp = rp;
        end else begin
          e_ox = P_X_Center; e_oy = P_Y_Center; e_dir = (N_X_Center < P_X_Center);
          m_pp = 0; m_np = rn;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge Clk); #1;
    n_act  += int'(proj_activate);
    n_kill += int'(proj_kill);
    n_hp   += int'(hit_player);
    n_hn   += int'(hit_npc);
    check("model", {proj_activate, proj_kill, proj_busy, hit_player, hit_npc, proj_owner,
                    Proj_Dir, Proj_Origin_X, Proj_Origin_Y},
          {e_act, e_kill, e_busy, e_hp, e_hn, e_own, e_dir, e_ox, e_oy});
  endtask

  task automatic tick();
    frame_clk = 1'b1; step();
    frame_clk = 1'b0; step();
  endtask

  task automatic clr();
    n_act = 0; n_kill = 0; n_hp = 0; n_hn = 0;
  endtask

  // in  = {Reset, battle_l, P_Shoot, N_Shoot, contact_npc, frame_clk}
  // exp = {activate, kill, busy, hit_npc, owner, dir}
  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{6'b100000, 6'b000000};
    tbl[1] = '{6'b010000, 6'b000000};
    tbl[2] = '{6'b011000, 6'b101000};
    tbl[3] = '{6'b011000, 6'b001000};
    tbl[4] = '{6'b010000, 6'b001000};
    tbl[5] = '{6'b010010, 6'b010100};
    tbl[6] = '{6'b011000, 6'b000000};
    tbl[7] = '{6'b011000, 6'b000000};

    Reset = 1; frame_clk = 0; battle_l = 0; P_Shoot = 0; N_Shoot = 0;
    contact_player = 0; contact_npc = 0;
    P_X_Center = 10'd260; P_Y_Center = 10'd387;
    N_X_Center = 10'd381; N_Y_Center = 10'd387;
    Proj_X_Curr = 10'd300;
    clr();
    #1;

    for (int i = 0; i < 8; i++) begin
      {Reset, battle_l, P_Shoot, N_Shoot, contact_npc, frame_clk} = tbl[i].in;
      step();
      check($sformatf("vec%0d", i),
            {proj_activate, proj_kill, proj_busy, hit_npc, proj_owner, Proj_Dir}, tbl[i].exp);
      if (i == 2) check("origin_p", {Proj_Origin_X, Proj_Origin_Y}, {10'd260, 10'd387});
    end

    // Pending request captured in cooldown is served once the 8th frame elapses.
    P_Shoot = 0; clr();
    repeat (7) tick();
    check("cooldown_hold", n_act, 0);
    tick();
    check("cooldown_release", n_act, 1);
    step();
    P_Shoot = 1; step(); P_Shoot = 0; step();
    contact_npc = 1; step();
    check("hit_npc_pulse", {hit_npc, proj_kill, proj_busy}, 3'b110);
    contact_npc = 0; clr();
    repeat (8) tick();
    repeat (4) step();
    check("flight_rise_dropped", n_act, 0);

    // Simultaneous requests: player first, then NPC (facing left).
    Reset = 1; step(); Reset = 0; battle_l = 1;
    step();
    P_Shoot = 1; N_Shoot = 1; step();
    check("both_first", {proj_activate, proj_owner}, 2'b10);
    step();
    contact_npc = 1; step(); contact_npc = 0;
    P_Shoot = 0; N_Shoot = 0; step();
    P_Shoot = 1; N_Shoot = 1; step();
    P_Shoot = 0; N_Shoot = 0; clr();
    repeat (8) tick();
    check("both_second", {n_act[1:0], proj_owner, Proj_Dir}, 4'b0111);
    check("origin_n", {Proj_Origin_X, Proj_Origin_Y}, {10'd381, 10'd387});
    step(); clr();
    contact_npc = 1; step(); contact_npc = 0; step();
    check("own_contact_ignored", n_hn + n_kill, 0);
    Proj_X_Curr = 10'd640; step();
    check("oob_kill", {proj_kill, hit_player, hit_npc}, 3'b100);
    Proj_X_Curr = 10'd300; clr();

    // Leftover player request, then a flight that times out on frame 160.
    repeat (8) tick();
    check("pending_player", {n_act[1:0], proj_owner}, 3'b010);
    step(); clr();
    repeat (MAXF - 1) tick();
    check("no_early_timeout", n_kill, 0);
    tick();
    check("timeout_kill", {n_kill[1:0], n_hp[0], n_hn[0]}, 4'b0100);

    // Battle dropped mid-flight with the player still pending.
    P_Shoot = 1; N_Shoot = 1; step();
    P_Shoot = 0; N_Shoot = 0; step(); clr();
    repeat (8) tick();
    check("rr_npc", {n_act[1:0], proj_owner}, 3'b011);
    step(); step(); clr();
    battle_l = 0; step();
    check("abort_kill", proj_kill, 1);
    step();
    check("abort_once", {n_kill[1:0], n_hp[0], n_hn[0], proj_busy}, 5'b01000);
    battle_l = 1; clr();
    repeat (10) step();
    check("pending_cleared", n_act, 0);
    P_Shoot = 1; step();
    check("new_rise", {proj_activate, proj_owner}, 2'b10);
    P_Shoot = 0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      Reset          = ($urandom_range(0, 299) == 0);
      battle_l       = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 4) == 0) P_Shoot = ~P_Shoot;
      if ($urandom_range(0, 4) == 0) N_Shoot = ~N_Shoot;
      contact_player = ($urandom_range(0, 29) == 0);
      contact_npc    = ($urandom_range(0, 29) == 0);
      Proj_X_Curr    = ($urandom_range(0, 29) == 0) ? 10'($urandom_range(640, 1023))
                                                    : 10'($urandom_range(0, 639));
      P_X_Center     = 10'($urandom_range(0, 639));
      P_Y_Center     = 10'($urandom_range(0, 479));
      N_X_Center     = ($urandom_range(0, 7) == 0) ? P_X_Center : 10'($urandom_range(0, 639));
      N_Y_Center     = 10'($urandom_range(0, 479));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
